// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared RV32I datapath types for the writeback stage
// Purpose: word/register typedefs, the bundle record carried through the
//          writeback skid buffer, and the per-lane regfile write port record.
// Ports:   none (package).
package rv32i_types;

    localparam int LANES_MAX = 4;

    typedef logic [31:0] rv32i_word;
    typedef logic [4:0]  rv32i_reg;

    // Sized for LANES_MAX so one type serves every LANES build; unused lanes
    // stay zero.
    typedef struct packed {
        logic      [LANES_MAX-1:0] lane_vld;
        rv32i_word [LANES_MAX-1:0] pc;
        rv32i_word [LANES_MAX-1:0] ir;
        logic      [LANES_MAX-1:0] ld_rf;
        rv32i_word [LANES_MAX-1:0] rd_data;
    } wb_bundle_t;

    typedef struct packed {
        logic      we;
        rv32i_reg  rd;
        rv32i_word wdata;
    } wb_rf_port_t;

endpackage

// File: rtl/wb_skid_buf.sv
// rtl/wb_skid_buf.sv - generic small FIFO with registered push-ready
// Purpose: holds up to DEPTH items in arrival order; push-ready is a flop so
//          the upstream never sees a combinational path from the pop side.
// Ports:   clk, rst_n (async active-low)
//          i_push_valid / o_push_ready / i_push_data : producer side
//          i_pop / o_pop_valid / o_pop_data          : consumer side (head)
module wb_skid_buf #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_push_valid,
    output logic o_push_ready,
    input  T     i_push_data,
    input  logic i_pop,
    output logic o_pop_valid,
    output T     o_pop_data
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_ready;
    T              r_mem [DEPTH];

    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_count_nxt;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign w_push      = i_push_valid && r_ready;
    assign w_pop       = i_pop && (r_count != '0);
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

    assign o_push_ready = r_ready;
    assign o_pop_valid  = (r_count != '0);
    assign o_pop_data   = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ready  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            r_count <= w_count_nxt;
            // Ready for next cycle follows the occupancy we are about to have.
            r_ready <= (w_count_nxt < CW'(DEPTH));
        end
    end

    // Storage carries no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

endmodule

// File: rtl/wb_stage_mlane.sv
// rtl/wb_stage_mlane.sv - multi-lane writeback stage with skid buffer and instret
// Purpose: accepts LANES-wide bundles from MEM, retires one bundle per cycle
//          into LANES regfile write ports (youngest lane wins on same rd),
//          mirrors them as a forwarding view, and counts retired instructions.
// Ports:   clk, rst_n (async active-low)
//          in_valid/in_ready, in_lane_vld, in_pc, in_ir, in_ld_rf, in_rd_data
//          stall                  : freezes retire, counters and outputs
//          rf_we/rf_rd/rf_wdata   : regfile write ports
//          fwd_vld/fwd_rd/fwd_data: forwarding view of the same ports
//          ret_pc                 : pc of youngest valid lane last retired
//          instret                : 64-bit retired-instruction count
module wb_stage_mlane
    import rv32i_types::*;
#(
    parameter int LANES = 2,
    parameter int XLEN  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES-1:0]      in_lane_vld,
    input  logic [LANES*XLEN-1:0] in_pc,
    input  logic [LANES*XLEN-1:0] in_ir,
    input  logic [LANES-1:0]      in_ld_rf,
    input  logic [LANES*XLEN-1:0] in_rd_data,
    input  logic                  stall,
    output logic [LANES-1:0]      rf_we,
    output logic [LANES*5-1:0]    rf_rd,
    output logic [LANES*XLEN-1:0] rf_wdata,
    output logic [LANES-1:0]      fwd_vld,
    output logic [LANES*5-1:0]    fwd_rd,
    output logic [LANES*XLEN-1:0] fwd_data,
    output logic [XLEN-1:0]       ret_pc,
    output logic [63:0]           instret
);

    wb_bundle_t                    w_in_bundle;
    wb_bundle_t                    w_head;
    logic                          w_head_vld;
    logic                          w_pop;

    logic [LANES-1:0][4:0]         w_rd;
    logic [LANES-1:0]              w_cand;
    logic [LANES-1:0]              w_kill;
    logic [2:0]                    w_cnt;
    rv32i_word                     w_last_pc;

    wb_rf_port_t [LANES-1:0]       r_port;
    rv32i_word                     r_ret_pc;
    logic [63:0]                   r_instret;

    logic                          w_unused_ok;

    always_comb begin
        w_in_bundle = '0;
        for (int i = 0; i < LANES; i++) begin
            w_in_bundle.lane_vld[i] = in_lane_vld[i];
            w_in_bundle.ld_rf[i]    = in_ld_rf[i];
            w_in_bundle.pc[i]       = rv32i_word'(in_pc[i*XLEN +: XLEN]);
            w_in_bundle.ir[i]       = rv32i_word'(in_ir[i*XLEN +: XLEN]);
            w_in_bundle.rd_data[i]  = rv32i_word'(in_rd_data[i*XLEN +: XLEN]);
        end
    end

    wb_skid_buf #(
        .T     (wb_bundle_t),
        .DEPTH (2)
    ) u_skid (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push_valid (in_valid),
        .o_push_ready (in_ready),
        .i_push_data  (w_in_bundle),
        .i_pop        (w_pop),
        .o_pop_valid  (w_head_vld),
        .o_pop_data   (w_head)
    );

    assign w_pop = w_head_vld && !stall;

    // Write candidates, same-rd kill (an older lane loses to any younger lane
    // writing the same register), lane popcount and youngest valid pc.
    always_comb begin
        w_rd      = '0;
        w_cand    = '0;
        w_kill    = '0;
        w_cnt     = '0;
        w_last_pc = r_ret_pc;
        for (int i = 0; i < LANES; i++) begin
            w_rd[i]   = w_head.ir[i][11:7];
            w_cand[i] = w_head.lane_vld[i] && w_head.ld_rf[i] && (w_head.ir[i][11:7] != 5'd0);
        end
        for (int i = 0; i < LANES; i++) begin
            for (int j = 0; j < LANES; j++) begin
                if ((j > i) && w_cand[j] && (w_rd[j] == w_rd[i])) begin
                    w_kill[i] = 1'b1;
                end
            end
        end
        // Ascending scan so the highest-index valid lane is the one kept.
        for (int i = 0; i < LANES; i++) begin
            w_cnt = w_cnt + 3'(w_head.lane_vld[i]);
            if (w_head.lane_vld[i]) begin
                w_last_pc = w_head.pc[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_port    <= '0;
            r_ret_pc  <= '0;
            r_instret <= '0;
        end else if (w_pop) begin
            for (int i = 0; i < LANES; i++) begin
                r_port[i].we    <= w_cand[i] && !w_kill[i];
                r_port[i].rd    <= w_rd[i];
                r_port[i].wdata <= w_head.rd_data[i];
            end
            r_ret_pc  <= w_last_pc;
            r_instret <= r_instret + 64'(w_cnt);
        end else begin
            // No retire: drop enables, keep rd/wdata as last shown.
            for (int i = 0; i < LANES; i++) begin
                r_port[i].we <= 1'b0;
            end
        end
    end

    always_comb begin
        rf_we    = '0;
        rf_rd    = '0;
        rf_wdata = '0;
        for (int i = 0; i < LANES; i++) begin
            rf_we[i]                 = r_port[i].we;
            rf_rd[i*5 +: 5]          = r_port[i].rd;
            rf_wdata[i*XLEN +: XLEN] = r_port[i].wdata[XLEN-1:0];
        end
    end

    assign fwd_vld  = rf_we;
    assign fwd_rd   = rf_rd;
    assign fwd_data = rf_wdata;
    assign ret_pc   = r_ret_pc[XLEN-1:0];
    assign instret  = r_instret;

    // Lanes above LANES and ir bits other than rd are carried but not consumed.
    assign w_unused_ok = ^{w_head, r_port, r_ret_pc};

endmodule

// File: tb/tb_wb_stage_mlane.sv
// tb/tb_wb_stage_mlane.sv - directed self-checking bench for wb_stage_mlane
module tb_wb_stage_mlane;

    localparam int LANES = 2;
    localparam int XLEN  = 32;

    logic                  clk;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [LANES-1:0]      in_lane_vld;
    logic [LANES*XLEN-1:0] in_pc;
    logic [LANES*XLEN-1:0] in_ir;
    logic [LANES-1:0]      in_ld_rf;
    logic [LANES*XLEN-1:0] in_rd_data;
    logic                  stall;
    logic [LANES-1:0]      rf_we;
    logic [LANES*5-1:0]    rf_rd;
    logic [LANES*XLEN-1:0] rf_wdata;
    logic [LANES-1:0]      fwd_vld;
    logic [LANES*5-1:0]    fwd_rd;
    logic [LANES*XLEN-1:0] fwd_data;
    logic [XLEN-1:0]       ret_pc;
    logic [63:0]           instret;

    int n_checks = 0;
    int n_errors = 0;

    wb_stage_mlane #(.LANES(LANES), .XLEN(XLEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_lane_vld(in_lane_vld),
        .in_pc      (in_pc),
        .in_ir      (in_ir),
        .in_ld_rf   (in_ld_rf),
        .in_rd_data (in_rd_data),
        .stall      (stall),
        .rf_we      (rf_we),
        .rf_rd      (rf_rd),
        .rf_wdata   (rf_wdata),
        .fwd_vld    (fwd_vld),
        .fwd_rd     (fwd_rd),
        .fwd_data   (fwd_data),
        .ret_pc     (ret_pc),
        .instret    (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk_ir(input logic [4:0] rd);
        return {20'd0, rd, 7'h33};
    endfunction

    task automatic drive(input logic [1:0] vld, input logic [1:0] ld,
                         input logic [31:0] pc1, input logic [31:0] pc0,
                         input logic [4:0] rd1, input logic [4:0] rd0,
                         input logic [31:0] d1, input logic [31:0] d0);
        in_valid    = 1'b1;
        in_lane_vld = vld;
        in_ld_rf    = ld;
        in_pc       = {pc1, pc0};
        in_ir       = {mk_ir(rd1), mk_ir(rd0)};
        in_rd_data  = {d1, d0};
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_lane_vld = '0;
        in_pc       = '0;
        in_ir       = '0;
        in_ld_rf    = '0;
        in_rd_data  = '0;
        stall       = 1'b0;

        // 1 reset
        repeat (3) tick();
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_rf_we", 64'(rf_we), 64'd0);
        chk("rst_fwd_vld", 64'(fwd_vld), 64'd0);
        chk("rst_instret", instret, 64'd0);
        chk("rst_ret_pc", 64'(ret_pc), 64'd0);
        chk("rst_rf_rd", 64'(rf_rd), 64'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("idle_rf_we", 64'(rf_we), 64'd0);
        end

        // 2 single bundle, one-cycle latency
        drive(2'b11, 2'b11, 32'h0000_1004, 32'h0000_1000, 5'd6, 5'd5, 32'h1234_5678, 32'hDEAD_BEEF);
        chk("s_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("s_lat_we", 64'(rf_we), 64'd0);
        tick();
        chk("s_rf_we", 64'(rf_we), 64'h3);
        chk("s_rf_rd", 64'(rf_rd), 64'({5'd6, 5'd5}));
        chk("s_rf_wdata", 64'(rf_wdata), 64'h1234_5678_DEAD_BEEF);
        chk("s_fwd_vld", 64'(fwd_vld), 64'h3);
        chk("s_fwd_rd", 64'(fwd_rd), 64'({5'd6, 5'd5}));
        chk("s_fwd_data", 64'(fwd_data), 64'h1234_5678_DEAD_BEEF);
        chk("s_instret", instret, 64'd2);
        chk("s_ret_pc", 64'(ret_pc), 64'h1004);
        tick();
        chk("s_after_we", 64'(rf_we), 64'd0);
        chk("s_hold_rd", 64'(rf_rd), 64'({5'd6, 5'd5}));

        // 3 same-rd conflict, then an x0 lane, then a bubble
        drive(2'b11, 2'b11, 32'h0000_2004, 32'h0000_2000, 5'd7, 5'd7, 32'h2, 32'h1);
        tick();
        drive(2'b11, 2'b11, 32'h0000_3004, 32'h0000_3000, 5'd9, 5'd0, 32'h99, 32'hAA);
        tick();
        in_valid = 1'b0;
        chk("c_rf_we", 64'(rf_we), 64'h2);
        chk("c_rf_rd", 64'(rf_rd), 64'({5'd7, 5'd7}));
        chk("c_wdata_l1", 64'(rf_wdata[63:32]), 64'h2);
        chk("c_instret", instret, 64'd4);
        chk("c_ret_pc", 64'(ret_pc), 64'h2004);
        tick();
        chk("x0_rf_we", 64'(rf_we), 64'h2);
        chk("x0_rf_rd", 64'(rf_rd), 64'({5'd9, 5'd0}));
        chk("x0_wdata_l0", 64'(rf_wdata[31:0]), 64'hAA);
        chk("x0_instret", instret, 64'd6);
        drive(2'b00, 2'b00, 32'h0000_4004, 32'h0000_4000, 5'd12, 5'd13, 32'h5, 32'h6);
        tick();
        in_valid = 1'b0;
        tick();
        chk("bub_rf_we", 64'(rf_we), 64'd0);
        chk("bub_instret", instret, 64'd6);
        chk("bub_ret_pc", 64'(ret_pc), 64'h3004);

        // 4 back-pressure: stall while offering three bundles
        stall = 1'b1;
        drive(2'b11, 2'b11, 32'h0000_5004, 32'h0000_5000, 5'd2, 5'd1, 32'h22, 32'h11);
        chk("bp_rdy0", 64'(in_ready), 64'd1);
        tick();
        drive(2'b01, 2'b11, 32'h0000_6004, 32'h0000_6000, 5'd8, 5'd3, 32'h88, 32'h33);
        chk("bp_rdy1", 64'(in_ready), 64'd1);
        tick();
        drive(2'b11, 2'b11, 32'h0000_7004, 32'h0000_7000, 5'd4, 5'd4, 32'h44, 32'h44);
        chk("bp_full", 64'(in_ready), 64'd0);
        chk("bp_we0", 64'(rf_we), 64'd0);
        tick();
        chk("bp_full2", 64'(in_ready), 64'd0);
        tick();
        chk("bp_we_stall", 64'(rf_we), 64'd0);
        chk("bp_instret", instret, 64'd6);
        stall    = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("bp_c_we", 64'(rf_we), 64'h3);
        chk("bp_c_rd", 64'(rf_rd), 64'({5'd2, 5'd1}));
        chk("bp_c_instret", instret, 64'd8);
        chk("bp_c_ret_pc", 64'(ret_pc), 64'h5004);
        chk("bp_rdy_back", 64'(in_ready), 64'd1);
        tick();
        chk("bp_d_we", 64'(rf_we), 64'h1);
        chk("bp_d_rd", 64'(rf_rd), 64'({5'd8, 5'd3}));
        chk("bp_d_instret", instret, 64'd9);
        chk("bp_d_ret_pc", 64'(ret_pc), 64'h6000);
        tick();
        chk("bp_e_dropped_we", 64'(rf_we), 64'd0);
        chk("bp_e_instret", instret, 64'd9);

        // 5 asynchronous reset with two bundles buffered
        stall = 1'b1;
        drive(2'b11, 2'b11, 32'h0000_8004, 32'h0000_8000, 5'd2, 5'd1, 32'h22, 32'h11);
        tick();
        drive(2'b11, 2'b11, 32'h0000_9004, 32'h0000_9000, 5'd4, 5'd3, 32'h44, 32'h33);
        tick();
        in_valid = 1'b0;
        chk("ar_full", 64'(in_ready), 64'd0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_we", 64'(rf_we), 64'd0);
        chk("ar_rd", 64'(rf_rd), 64'd0);
        chk("ar_wdata", 64'(rf_wdata), 64'd0);
        chk("ar_instret", instret, 64'd0);
        chk("ar_ret_pc", 64'(ret_pc), 64'd0);
        chk("ar_in_ready", 64'(in_ready), 64'd1);
        #1;
        rst_n = 1'b1;
        stall = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("ar_post_we", 64'(rf_we), 64'd0);
            chk("ar_post_instret", instret, 64'd0);
        end

        // 6 counter wrap
        drive(2'b11, 2'b11, 32'h0000_A004, 32'h0000_A000, 5'd11, 5'd10, 32'hB, 32'hA);
        tick();
        in_valid = 1'b0;
        force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.r_instret;
        #1;
        chk("wr_preset", instret, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        chk("wr_instret", instret, 64'd1);
        chk("wr_we", 64'(rf_we), 64'h3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
